// File: rtl/mem_access_ctrl.sv
// Request/response front end for a dual-read-port, single-write-port memory.
// Handles one request at a time and keeps a saturating count of rejected requests.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WR_LIMIT = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic              rsp_err,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [ADDR_W-1:0] mem_rd_addr_a,
  output logic [ADDR_W-1:0] mem_rd_addr_b,
  input  logic [DATA_W-1:0] mem_rd_data_a,
  input  logic [DATA_W-1:0] mem_rd_data_b,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdCapture,
    StWrIssue,
    StResp
  } state_e;

  localparam logic [1:0] OpRead     = 2'b00;
  localparam logic [1:0] OpReadPair = 2'b01;
  localparam logic [1:0] OpWrite    = 2'b10;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsp_data_a_q, rsp_data_a_d;
  logic [DATA_W-1:0]   rsp_data_b_q, rsp_data_b_d;
  logic                rsp_err_q, rsp_err_d;
  logic [7:0]          err_count_q, err_count_d;
  logic                reject;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    wdata_d      = wdata_q;
    rsp_data_a_d = rsp_data_a_q;
    rsp_data_b_d = rsp_data_b_q;
    rsp_err_d    = rsp_err_q;
    err_count_d  = err_count_q;
    reject       = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d     = req_op;
          addr_a_d = req_addr_a;
          addr_b_d = req_addr_b;
          wdata_d  = req_wdata;
          case (req_op)
            OpRead, OpReadPair: state_d = StRdIssue;
            OpWrite: begin
              if (32'(req_addr_a) < WR_LIMIT) state_d = StWrIssue;
              else                            reject  = 1'b1;
            end
            default: reject = 1'b1;
          endcase
          // Rejects skip memory entirely and answer on the next cycle.
          if (reject) begin
            state_d      = StResp;
            rsp_err_d    = 1'b1;
            rsp_data_a_d = '0;
            rsp_data_b_d = '0;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end
        end
      end
      StRdIssue: state_d = StRdCapture;
      StRdCapture: begin
        // Memory registers the address, so read data is valid in this state.
        rsp_data_a_d = mem_rd_data_a;
        rsp_data_b_d = (op_q == OpReadPair) ? mem_rd_data_b : '0;
        rsp_err_d    = 1'b0;
        state_d      = StResp;
      end
      StWrIssue: begin
        rsp_data_a_d = wdata_q;
        rsp_data_b_d = '0;
        rsp_err_d    = 1'b0;
        state_d      = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      wdata_q      <= '0;
      rsp_data_a_q <= '0;
      rsp_data_b_q <= '0;
      rsp_err_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      wdata_q      <= wdata_d;
      rsp_data_a_q <= rsp_data_a_d;
      rsp_data_b_q <= rsp_data_b_d;
      rsp_err_q    <= rsp_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign rsp_valid     = (state_q == StResp);
  assign mem_write     = (state_q == StWrIssue);
  assign mem_wr_addr   = addr_a_q;
  assign mem_wr_data   = wdata_q;
  assign mem_rd_addr_a = addr_a_q;
  assign mem_rd_addr_b = addr_b_q;
  assign rsp_data_a    = rsp_data_a_q;
  assign rsp_data_b    = rsp_data_b_q;
  assign rsp_err       = rsp_err_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a registered-read memory model.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned WR_LIMIT = 6;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr_a;
  logic [ADDR_W-1:0] req_addr_b;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data_a;
  logic [DATA_W-1:0] rsp_data_b;
  logic              rsp_err;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [ADDR_W-1:0] mem_rd_addr_a;
  logic [ADDR_W-1:0] mem_rd_addr_b;
  logic [DATA_W-1:0] mem_rd_data_a;
  logic [DATA_W-1:0] mem_rd_data_b;
  logic [7:0]        err_count;

  int checks   = 0;
  int failures = 0;

  logic              preload;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  mem_access_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .WR_LIMIT(WR_LIMIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr_a   (req_addr_a),
    .req_addr_b   (req_addr_b),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data_a   (rsp_data_a),
    .rsp_data_b   (rsp_data_b),
    .rsp_err      (rsp_err),
    .mem_write    (mem_write),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_addr_a(mem_rd_addr_a),
    .mem_rd_addr_b(mem_rd_addr_b),
    .mem_rd_data_a(mem_rd_data_a),
    .mem_rd_data_b(mem_rd_data_b),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memory; preload happens through the same process as writes.
  always @(posedge clk) begin
    if (preload) begin
      mem[3] <= 16'h1234;
      mem[4] <= 16'h0404;
      mem[7] <= 16'hBEEF;
    end else if (mem_write) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
    mem_rd_data_a <= mem[mem_rd_addr_a];
    mem_rd_data_b <= mem[mem_rd_addr_b];
  end

  // Offer one request at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                       input logic [ADDR_W-1:0] b, input logic [DATA_W-1:0] wd);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr_a = a;
    req_addr_b = b;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (mem_rd_addr_a !== '0 || mem_wr_data !== '0) begin failures++;
      $display("FAIL reset_regs got addr_a=%h wdata=%h exp=0", mem_rd_addr_a, mem_wr_data); end
  endtask

  task automatic test_read_pair();
    rsp_ready = 1'b1;
    issue(2'b01, 12'd3, 12'd7, 16'h0);
    // Clock 1 after accept edge counted as clock 1: RD_ISSUE.
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++;
      $display("FAIL rdp_issue got valid=%b ready=%b exp 0 0", rsp_valid, req_ready); end
    checks++; if (mem_rd_addr_a !== 12'd3 || mem_rd_addr_b !== 12'd7) begin failures++;
      $display("FAIL rdp_addr got a=%0d b=%0d exp 3 7", mem_rd_addr_a, mem_rd_addr_b); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rdp_capture_valid got=%b exp=0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rdp_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data_a !== 16'h1234 || rsp_data_b !== 16'hBEEF || rsp_err !== 1'b0) begin failures++;
      $display("FAIL rdp_data got a=%h b=%h err=%b exp 1234 beef 0", rsp_data_a, rsp_data_b, rsp_err); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++;
      $display("FAIL rdp_return got ready=%b valid=%b exp 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_write_readback();
    rsp_ready = 1'b1;
    issue(2'b10, 12'd5, 12'd0, 16'hA5A5);
    checks++; if (mem_write !== 1'b1 || mem_wr_addr !== 12'd5 || mem_wr_data !== 16'hA5A5) begin failures++;
      $display("FAIL wr_strobe got we=%b addr=%0d data=%h exp 1 5 a5a5", mem_write, mem_wr_addr, mem_wr_data); end
    @(negedge clk);
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL wr_single_pulse got=%b exp=0", mem_write); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data_a !== 16'hA5A5 || rsp_data_b !== 16'h0 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL wr_rsp got v=%b a=%h b=%h err=%b exp 1 a5a5 0 0",
                           rsp_valid, rsp_data_a, rsp_data_b, rsp_err); end
    @(negedge clk);
    // addr_b points at a non-zero word; read-one must still return zero there.
    issue(2'b00, 12'd5, 12'd7, 16'h0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data_a !== 16'hA5A5 || rsp_data_b !== 16'h0) begin failures++;
      $display("FAIL rd1_data got v=%b a=%h b=%h exp 1 a5a5 0", rsp_valid, rsp_data_a, rsp_data_b); end
    @(negedge clk);
  endtask

  task automatic test_reject();
    rsp_ready = 1'b1;
    issue(2'b10, 12'd6, 12'd0, 16'h7777);
    checks++; if (mem_write !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin failures++;
      $display("FAIL rej_wr got we=%b v=%b err=%b exp 0 1 1", mem_write, rsp_valid, rsp_err); end
    checks++; if (rsp_data_a !== 16'h0 || rsp_data_b !== 16'h0 || err_count !== 8'd1) begin failures++;
      $display("FAIL rej_wr_data got a=%h b=%h cnt=%0d exp 0 0 1", rsp_data_a, rsp_data_b, err_count); end
    @(negedge clk);
    issue(2'b11, 12'd1, 12'd2, 16'h0);
    checks++; if (rsp_err !== 1'b1 || err_count !== 8'd2) begin failures++;
      $display("FAIL rej_op11 got err=%b cnt=%0d exp 1 2", rsp_err, err_count); end
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      issue(2'b11, 12'd0, 12'd0, 16'h0);
      @(negedge clk);
    end
    checks++; if (err_count !== 8'd102) begin failures++; $display("FAIL rej_cnt_102 got=%0d exp=102", err_count); end
    for (int i = 0; i < 200; i++) begin
      issue(2'b10, 12'hFFF, 12'd0, 16'h0);
      @(negedge clk);
    end
    checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL rej_cnt_sat got=%0d exp=255", err_count); end
  endtask

  task automatic test_stall();
    rsp_ready = 1'b0;
    issue(2'b00, 12'd3, 12'd0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    // A legal write offered during the stall must be ignored.
    req_valid  = 1'b1;
    req_op     = 2'b10;
    req_addr_a = 12'd2;
    req_addr_b = 12'd9;
    req_wdata  = 16'h1111;
    for (int i = 0; i < 10; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data_a !== 16'h1234 || rsp_data_b !== 16'h0 ||
                    req_ready !== 1'b0 || mem_write !== 1'b0 || mem_rd_addr_a !== 12'd3) begin
        failures++; $display("FAIL stall_hold cyc=%0d got v=%b a=%h b=%h rdy=%b we=%b addr=%0d exp 1 1234 0 0 0 3",
                             i, rsp_valid, rsp_data_a, rsp_data_b, req_ready, mem_write, mem_rd_addr_a); end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++;
      $display("FAIL stall_release got ready=%b valid=%b exp 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_reset_mid_write();
    rsp_ready = 1'b1;
    issue(2'b10, 12'd4, 12'd0, 16'h5555);
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL rstw_pre_we got=%b exp=1", mem_write); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || err_count !== 8'd0) begin
      failures++; $display("FAIL rstw_async got we=%b rdy=%b v=%b cnt=%0d exp 0 1 0 0",
                           mem_write, req_ready, rsp_valid, err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstw_no_rsp got=%b exp=0", rsp_valid); end
    issue(2'b00, 12'd4, 12'd0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data_a !== 16'h0404) begin failures++;
      $display("FAIL rstw_mem_kept got v=%b a=%h exp 1 0404", rsp_valid, rsp_data_a); end
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    preload    = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr_a = '0;
    req_addr_b = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    preload = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    test_read_pair();
    test_write_readback();
    test_reject();
    test_stall();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
